// File: rtl/fir_pipelined_param.sv
// Programmable-coefficient transposed-form FIR with a valid-tagged sample stream and synchronous flush.
// Optional FIR_SAT_EN: saturate data_out to OUT_W bits and expose a sticky o_sat_flag.
module fir_pipelined_param #(
  parameter int TAPS     = 5,
  parameter int SAMPLE_W = 6,
  parameter int COEF_W   = 5,
  parameter int ACC_W    = SAMPLE_W + COEF_W + $clog2(TAPS),
  parameter int OUT_W    = 14,
  parameter int ADDR_W   = $clog2(TAPS)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_in_valid,
  input  logic [SAMPLE_W-1:0] i_data_in,
  input  logic                i_coef_wr_en,
  input  logic [ADDR_W-1:0]   i_coef_addr,
  input  logic [COEF_W-1:0]   i_coef_data,
  output logic                o_out_valid,
  output logic [OUT_W-1:0]    o_data_out
`ifdef FIR_SAT_EN
  ,
  output logic                o_sat_flag
`endif
);

  logic [COEF_W-1:0] r_coef [TAPS];
  logic [ACC_W-1:0]  r_prod [TAPS];
  logic [ACC_W-1:0]  r_acc  [TAPS];
  logic              r_v1;
  logic              r_v2;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_data_out;
  logic [ACC_W-1:0]  w_prod [TAPS];
  logic [OUT_W-1:0]  w_out;

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = ACC_W'(r_coef[k]) * ACC_W'(i_data_in);
    end
  end

  // Decoding per tap means out-of-range addresses simply match nothing.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
    end else if (i_coef_wr_en) begin
      for (int k = 0; k < TAPS; k++) begin
        if (i_coef_addr == ADDR_W'(k)) r_coef[k] <= i_coef_data;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= '0;
        r_acc[k]  <= '0;
      end
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (i_flush) begin
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= '0;
        r_acc[k]  <= '0;
      end
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= i_in_valid;
      r_v2 <= r_v1;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= w_prod[k];
      // The adder chain only shifts on valid samples, so gaps leave the history untouched.
      if (r_v1) begin
        r_acc[TAPS-1] <= r_prod[TAPS-1];
        for (int k = 0; k < TAPS - 1; k++) r_acc[k] <= r_prod[k] + r_acc[k+1];
      end
    end
  end

`ifdef FIR_SAT_EN
  localparam logic [ACC_W:0] SAT_LIM = (ACC_W+1)'(1) << OUT_W;
  logic w_sat;
  logic r_sat;
  assign w_sat = ({1'b0, r_acc[0]} >= SAT_LIM);
  assign w_out = w_sat ? {OUT_W{1'b1}} : r_acc[0][OUT_W-1:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sat <= 1'b0;
    end else if (!i_flush && r_v2 && w_sat) begin
      r_sat <= 1'b1;
    end
  end
  assign o_sat_flag = r_sat;
`else
  assign w_out = r_acc[0][OUT_W-1:0];
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      if (r_v2) r_data_out <= w_out;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_data_out  = r_data_out;

endmodule

// File: tb/tb_fir_pipelined_param.sv
// Bench for fir_pipelined_param: default-width instance plus an OUT_W=11 instance sharing all inputs.
// Narrow-instance expectations follow FIR_SAT_EN (saturate) or not (wrap).
module tb_fir_pipelined_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  data_in = '0;
  logic        coef_wr_en = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [4:0]  coef_data = '0;
  logic        ov_w, ov_n;
  logic [13:0] dout_w;
  logic [10:0] dout_n;
  logic        sat_w, sat_n;

  int n_checks = 0;
  int n_pass   = 0;
  logic sat_exp = 1'b0;

  always #5 clk = ~clk;

  fir_pipelined_param u_wide (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
    .i_data_in(data_in), .i_coef_wr_en(coef_wr_en), .i_coef_addr(coef_addr),
    .i_coef_data(coef_data), .o_out_valid(ov_w), .o_data_out(dout_w)
`ifdef FIR_SAT_EN
    , .o_sat_flag(sat_w)
`endif
  );

  fir_pipelined_param #(.OUT_W(11)) u_narrow (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(in_valid),
    .i_data_in(data_in), .i_coef_wr_en(coef_wr_en), .i_coef_addr(coef_addr),
    .i_coef_data(coef_data), .o_out_valid(ov_n), .o_data_out(dout_n)
`ifdef FIR_SAT_EN
    , .o_sat_flag(sat_n)
`endif
  );

`ifndef FIR_SAT_EN
  assign sat_w = 1'b0;
  assign sat_n = 1'b0;
`endif

  typedef struct {
    logic fl;
    logic vld;
    int   din;
    logic ov;
    int   dout;
  } vec_t;

  vec_t tbl[$];

  function automatic int narrow(input int v);
`ifdef FIR_SAT_EN
    return (v > 2047) ? 2047 : v;
`else
    return v & 2047;
`endif
  endfunction

  task automatic add(input logic fl, input logic vld, input int din, input logic ov, input int dout);
    vec_t r;
    r.fl = fl; r.vld = vld; r.din = din; r.ov = ov; r.dout = dout;
    tbl.push_back(r);
  endtask

  task automatic cmp(input string nm, input string what, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
  endtask

  task automatic tick(input logic fl, input logic vld, input int din,
                      input logic wr = 1'b0, input int addr = 0, input int cd = 0);
    @(negedge clk);
    flush = fl; in_valid = vld; data_in = din[5:0];
    coef_wr_en = wr; coef_addr = addr[2:0]; coef_data = cd[4:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic eov, input int ed);
`ifdef FIR_SAT_EN
    if (eov && ed > 2047) sat_exp = 1'b1;
`endif
    cmp(nm, "out_valid", int'(ov_w), int'(eov));
    cmp(nm, "data_out", int'(dout_w), ed);
    cmp(nm, "out_valid11", int'(ov_n), int'(eov));
    cmp(nm, "data_out11", int'(dout_n), narrow(ed));
`ifdef FIR_SAT_EN
    cmp(nm, "sat_flag", int'(sat_w), 0);
    cmp(nm, "sat_flag11", int'(sat_n), int'(sat_exp));
`endif
  endtask

  task automatic write_coefs(input int b0, input int b1, input int b2, input int b3, input int b4);
    tick(0, 0, 0, 1, 0, b0);
    tick(0, 0, 0, 1, 1, b1);
    tick(0, 0, 0, 1, 2, b2);
    tick(0, 0, 0, 1, 3, b3);
    tick(0, 0, 0, 1, 4, b4);
    tick(0, 0, 0);
  endtask

  task automatic run_impulse(input string nm, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
    tick(0, 1, 1);
    tick(0, 1, 0);
    tick(0, 1, 0); check(nm, 1, e0);
    tick(0, 1, 0); check(nm, 1, e1);
    tick(0, 1, 0); check(nm, 1, e2);
    tick(0, 0, 0); check(nm, 1, e3);
    tick(0, 0, 0); check(nm, 1, e4);
    tick(0, 0, 0); check(nm, 0, e4);
  endtask

  initial begin
    // impulse with b = {3,7,20,7,3}
    add(0,1,1, 0,0);  add(0,1,0, 0,0);  add(0,1,0, 1,3);  add(0,1,0, 1,7);
    add(0,1,0, 1,20); add(0,1,0, 1,7);  add(0,0,0, 1,3);  add(0,0,0, 1,0);
    add(0,0,0, 0,0);
    // continuous step of 63
    add(0,1,63, 0,0);    add(0,1,63, 0,0);    add(0,1,63, 1,189);  add(0,1,63, 1,630);
    add(0,1,63, 1,1890); add(0,1,63, 1,2331); add(0,1,63, 1,2520); add(0,1,63, 1,2520);
    // flush drops a coincident sample and holds data_out, then a gapped step
    add(1,1,63, 0,2520);
    add(0,1,63, 0,2520); add(0,0,0, 0,2520);
    add(0,1,63, 1,189);  add(0,0,0, 0,189);
    add(0,1,63, 1,630);  add(0,0,0, 0,630);
    add(0,1,63, 1,1890); add(0,0,0, 0,1890);
    add(0,1,63, 1,2331); add(0,0,0, 0,2331);
    add(0,0,0, 1,2520);  add(0,0,0, 0,2520);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    write_coefs(3, 7, 20, 7, 3);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].fl, tbl[i].vld, tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].ov, tbl[i].dout);
    end

    // mid-stream write of b[2]=0, out-of-range writes ignored
    tick(0, 1, 63, 1, 2, 0);
    tick(0, 1, 63, 1, 6, 31);
    tick(0, 1, 63, 1, 5, 31);
    tick(0, 1, 63, 1, 7, 31);
    repeat (6) tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    run_impulse("coef_wr", 3, 7, 0, 7, 3);

    // asynchronous reset with two results in flight
    tick(0, 1, 1);
    tick(0, 1, 0);
    tick(0, 1, 0); check("pre_rst", 1, 3);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    sat_exp = 1'b0;
    #1;
    check("rst_async", 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      check("no_stale", 0, 0);
    end
    run_impulse("zero_coef", 0, 0, 0, 0, 0);

    // flush with a coincident sample; coefficient write on the flush edge still applies
    write_coefs(3, 7, 0, 7, 3);
    tick(1, 1, 1, 1, 2, 20);
    check("flush", 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      check("flush_drop", 0, 0);
    end
    run_impulse("flush_keep", 3, 7, 20, 7, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_pipelined_param.md
Name: fir_pipelined_param

Overview:
- Parametrised, programmable-coefficient successor to the fixed 5-tap pipelined FIR datapath.
- Computes unsigned y[n] = sum over k = 0..TAPS-1 of b[k] * x[n-k], using a registered-multiply, transposed-form adder chain.
- Adds a valid-tagged sample stream, run-time coefficient writes, a synchronous flush and a configurable output width.
- Sits between the sample source and the downstream output consumer in the filter datapath.

Parameters:
- TAPS, 5, number of filter taps (>= 2).
- SAMPLE_W, 6, unsigned sample width.
- COEF_W, 5, unsigned coefficient width.
- ACC_W, SAMPLE_W+COEF_W+$clog2(TAPS), full-precision accumulator width (14 at defaults).
- OUT_W, 14, data_out width; must be <= ACC_W.
- ADDR_W, $clog2(TAPS), coefficient address width (3 at defaults).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of datapath state; coefficients are kept.
- in_valid  in  1  data_in is a sample on this edge.
- data_in  in  SAMPLE_W  unsigned sample x[n].
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  ADDR_W  tap index k to write.
- coef_data  in  COEF_W  new value of b[k].
- out_valid  out  1  data_out holds a new y[n].
- data_out  out  OUT_W  filter result.
- sat_flag  out  1  sticky overflow flag; exists only with FIR_SAT_EN.

Behaviour:
- Reset (asynchronous, active-high): all of the following are cleared to 0 immediately and held while reset=1.
  - coefficient bank b[0..TAPS-1]
  - product registers p[k] and accumulators acc[k]
  - valid stages v1, v2
  - data_out, out_valid, sat_flag
- Stage 1, every edge:
  - p[k] <= b[k] * data_in for all k.
  - v1 <= in_valid.
  - p[k] is ACC_W wide and zero-extended.
- Stage 2, only on edges where v1=1:
  - acc[TAPS-1] <= p[TAPS-1].
  - acc[k] <= p[k] + acc[k+1] for k < TAPS-1.
  - When v1=0, acc holds its value.
- Valid stages: v2 <= v1 every edge.
- Output stage, only on edges where v2=1: data_out <= f(acc[0]).
  - Without FIR_SAT_EN: f = acc[0][OUT_W-1:0].
- out_valid: out_valid <= v2 every edge, so it is a one-cycle pulse per result.
- Latency: a sample accepted at edge N produces its data_out with out_valid=1 after edge N+2.
- Throughput: one sample per cycle.
- Sample indexing:
  - The filter history advances only on valid samples.
  - Gaps in in_valid do not insert zeros and do not change results.
- No overflow inside ACC_W: the accumulator is exact by construction.
- Coefficient writes:
  - On an edge with coef_wr_en=1 and coef_addr < TAPS, b[coef_addr] <= coef_data.
  - Writes with coef_addr >= TAPS are ignored.
  - A product captured on the same edge as a write uses the old coefficient; the new value applies from the next edge.
  - A write does not flush in-flight partial sums, so results straddling a write mix old and new coefficients.
- Flush (synchronous):
  - Effect: p, acc, v1, v2 and out_valid are cleared to 0 on that edge; data_out holds.
  - Coefficients and sat_flag are kept.
  - Priority: flush beats in_valid on the same edge, and that sample is dropped.
  - Coefficient writes on a flush edge still apply.
- Reset mid-stream: in-flight results are lost; no out_valid is asserted for them after reset deasserts.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - f = saturate(acc[0]): the result is 2^OUT_W - 1 if acc[0] >= 2^OUT_W, otherwise acc[0].
  - sat_flag goes high on the output edge where saturation occurs and stays high until reset.
  - The sat_flag port exists.
- Undefined:
  - The output wraps to the low OUT_W bits.
  - There is no sat_flag port and no saturation logic.
- With OUT_W = ACC_W both builds are identical in data_out.

Test Plan:
- Program b = {3,7,20,7,3}; apply in_valid samples 1,0,0,0,0,0 → data_out 3,7,20,7,3,0, each appearing 2 edges after its sample.
- Same coefficients; apply continuous 63s → 189,630,1890,2331,2520, then steady 2520.
- Same step, but with in_valid deasserted on every other cycle → identical value sequence, and out_valid pulses spaced to match the input spacing.
- OUT_W=11 with step 63 → with FIR_SAT_EN: 189,630,1890,2047,2047, and sat_flag rises on the 4th result. Without it: 189,630,1890,283,472.
- Write b[2]=0 mid-stream, then write to coef_addr=6 → after the pipeline drains, impulse response is 3,7,0,7,3; the out-of-range write has no effect.
- Assert reset asynchronously between edges with 2 results in flight → outputs go to 0 immediately, no stale out_valid afterward, coefficients read back as zero (impulse response all 0). Flush with a coincident valid sample → that sample is dropped, and the coefficients are retained.
